// File: rtl/maple_data_encoder.sv
// Maple bus payload encoder: serialises AXI4-Stream bytes onto SDCKA/SDCKB using alternating-clock encoding.
// Optional MAPLE_CRC_APPEND_EN appends an XOR checksum byte after the TLAST byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | lines 1/1, waiting for START
// S_LOAD   | TREADY=1, waiting for a payload byte (lines 1/1)
// S_SETUP  | clock line 1, data line carries the bit
// S_STROBE | clock line 0, receiver samples the data line
// S_HOLD   | clock line 1, data line still carries the bit
// S_FINISH | lines 1/1, DONE for one cycle
module maple_data_encoder #(
  parameter int TICKS_PER_PHASE      = 2,
  parameter int C_S_AXIS_TDATA_WIDTH = 8
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic                            START,
  output logic                            DONE,
  output logic                            SDCKA,
  output logic                            SDCKB,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                            BUSY
);

  localparam logic [7:0] PHASE_RELOAD = 8'(TICKS_PER_PHASE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  phase_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        last_flag;
  logic        phase_done;
  logic        in_bit;
  logic        byte_end;
  logic        clk_level;
  logic        data_bit;
`ifdef MAPLE_CRC_APPEND_EN
  logic [7:0]  crc;
  logic        crc_sent;
`endif

  assign phase_done = (phase_cnt == 8'd0);
  assign in_bit     = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign byte_end   = (state == S_HOLD) && phase_done && (bit_idx == 3'd0);
  assign clk_level  = (state != S_STROBE);
  assign data_bit   = shift_reg[bit_idx];

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (START) next_state = S_LOAD;
      S_LOAD:   if (S_AXIS_TVALID) next_state = S_SETUP;
      S_SETUP:  if (phase_done) next_state = S_STROBE;
      S_STROBE: if (phase_done) next_state = S_HOLD;
      S_HOLD: begin
        if (phase_done) begin
          if (bit_idx != 3'd0)
            next_state = S_SETUP;
          else if (!last_flag)
            next_state = S_LOAD;
`ifdef MAPLE_CRC_APPEND_EN
          else if (!crc_sent)
            next_state = S_SETUP;
`endif
          else
            next_state = S_FINISH;
        end
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Odd bit_idx means even bit position, where SDCKA carries the clock.
  always_comb begin
    SDCKA = 1'b1;
    SDCKB = 1'b1;
    if (in_bit) begin
      if (bit_idx[0]) begin
        SDCKA = clk_level;
        SDCKB = data_bit;
      end else begin
        SDCKA = data_bit;
        SDCKB = clk_level;
      end
    end
  end

  assign S_AXIS_TREADY = (state == S_LOAD);
  assign DONE          = (state == S_FINISH);
  assign BUSY          = (state != S_IDLE);

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state     <= S_IDLE;
      phase_cnt <= 8'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      last_flag <= 1'b0;
`ifdef MAPLE_CRC_APPEND_EN
      crc       <= 8'd0;
      crc_sent  <= 1'b0;
`endif
    end else begin
      state <= next_state;

      // Down-counter reloads whenever a phase ends or outside the bit phases.
      if (in_bit && !phase_done)
        phase_cnt <= phase_cnt - 8'd1;
      else
        phase_cnt <= PHASE_RELOAD;

      if ((state == S_LOAD) && S_AXIS_TVALID) begin
        shift_reg <= S_AXIS_TDATA;
        last_flag <= S_AXIS_TLAST;
        bit_idx   <= 3'd7;
`ifdef MAPLE_CRC_APPEND_EN
        crc       <= crc ^ S_AXIS_TDATA;
`endif
      end else if ((state == S_HOLD) && phase_done) begin
        bit_idx <= bit_idx - 3'd1;
      end

`ifdef MAPLE_CRC_APPEND_EN
      if ((state == S_IDLE) && START) begin
        crc      <= 8'd0;
        crc_sent <= 1'b0;
      end
      // bit_idx wraps 0 -> 7 above, so the checksum byte starts at its MSB.
      if (byte_end && last_flag && !crc_sent) begin
        shift_reg <= crc;
        crc_sent  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_maple_data_encoder.sv
// Randomised bench for maple_data_encoder: two instances (TICKS_PER_PHASE 1 and 2) replay
// per-cycle stimulus/expected-line queues built from the bus encoding rules.
module tb_maple_data_encoder;

  typedef struct {
    bit       rst;
    bit       start;
    bit       tvalid;
    bit       tlast;
    bit [7:0] tdata;
    bit [4:0] exp;
    bit       chk;
    bit       txn;
    int       lat;
  } ent_t;

  // expected vector layout: {SDCKA, SDCKB, TREADY, DONE, BUSY}
  localparam bit [4:0] EXP_IDLE = 5'b11000;
  localparam bit [4:0] EXP_LOAD = 5'b11101;
  localparam bit [4:0] EXP_FIN  = 5'b11011;

  logic       clk;
  logic       rst0, start0, tvalid0, tlast0;
  logic [7:0] tdata0;
  logic       a0, b0, tready0, done0, busy0;
  logic       rst1, start1, tvalid1, tlast1;
  logic [7:0] tdata1;
  logic       a1, b1, tready1, done1, busy1;

  ent_t       bq[$];
  ent_t       q0[$];
  ent_t       q1[$];
  logic [7:0] tx_bytes[$];
  int         tx_stalls[$];
  int         checks = 0;
  int         errors = 0;

  maple_data_encoder #(.TICKS_PER_PHASE(1), .C_S_AXIS_TDATA_WIDTH(8)) dut0 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst0), .START(start0), .DONE(done0),
    .SDCKA(a0), .SDCKB(b0), .S_AXIS_TVALID(tvalid0), .S_AXIS_TREADY(tready0),
    .S_AXIS_TLAST(tlast0), .S_AXIS_TDATA(tdata0), .BUSY(busy0)
  );

  maple_data_encoder #(.TICKS_PER_PHASE(2), .C_S_AXIS_TDATA_WIDTH(8)) dut1 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst1), .START(start1), .DONE(done1),
    .SDCKA(a1), .SDCKB(b1), .S_AXIS_TVALID(tvalid1), .S_AXIS_TREADY(tready1),
    .S_AXIS_TLAST(tlast1), .S_AXIS_TDATA(tdata1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(bit start, bit tvalid, bit [7:0] tdata, bit tlast, bit [4:0] exp);
    ent_t e;
    e.rst = 1'b0; e.start = start; e.tvalid = tvalid; e.tdata = tdata; e.tlast = tlast;
    e.exp = exp; e.chk = 1'b1; e.txn = 1'b0; e.lat = -1;
    return e;
  endfunction

  task automatic push_noise(input bit [4:0] exp, input bit allow_start);
    bq.push_back(mk(allow_start && ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), exp));
  endtask

  // One byte on the wire: MSB first, clock role alternating between lines per bit position.
  task automatic push_bits(input int T, input bit [7:0] b, input bit noise);
    for (int p = 0; p < 8; p++) begin
      for (int ph = 0; ph < 3; ph++) begin
        for (int t = 0; t < T; t++) begin
          bit d, c;
          bit [4:0] x;
          d = b[7 - p];
          c = (ph != 1);
          x = (p % 2 == 0) ? {c, d, 3'b001} : {d, c, 3'b001};
          push_noise(x, noise);
        end
      end
    end
  endtask

  task automatic build_txn(input int T, input int gap, input bit noise);
    int   n, lat, stall_sum;
    ent_t e;
`ifdef MAPLE_CRC_APPEND_EN
    bit [7:0] crc;
    crc = 8'h00;
`endif
    for (int g = 0; g < gap; g++) push_noise(EXP_IDLE, 1'b0);
    n = tx_bytes.size();
    stall_sum = 0;
    for (int i = 0; i < n; i++) begin
      stall_sum += tx_stalls[i];
`ifdef MAPLE_CRC_APPEND_EN
      crc ^= tx_bytes[i];
`endif
    end
    lat = n + stall_sum + 24 * T * n + 1;
`ifdef MAPLE_CRC_APPEND_EN
    lat += 24 * T;
`endif
    e = mk(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), EXP_IDLE);
    e.txn = 1'b1;
    e.lat = lat;
    bq.push_back(e);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < tx_stalls[i]; s++)
        bq.push_back(mk(noise && ($urandom_range(0, 7) == 0), 1'b0, 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), EXP_LOAD));
      bq.push_back(mk(noise && ($urandom_range(0, 7) == 0), 1'b1, tx_bytes[i], (i == n - 1), EXP_LOAD));
      push_bits(T, tx_bytes[i], noise);
    end
`ifdef MAPLE_CRC_APPEND_EN
    push_bits(T, crc, noise);
`endif
    push_noise(EXP_FIN, noise);
  endtask

  // Reset lands k cycles into the bit phases of 0x3C; lines must go idle and DONE stay low.
  task automatic build_reset_mid(input int T, input int k);
    ent_t e;
    int   base;
    e = mk(1'b1, 1'b0, 8'h00, 1'b0, EXP_IDLE);
    e.txn = 1'b1;
    e.lat = 24 * T + 2;
    bq.push_back(e);
    bq.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1, EXP_LOAD));
    base = bq.size();
    push_bits(T, 8'h3C, 1'b0);
    while (bq.size() > base + k) e = bq.pop_back();
    e = bq.pop_back();
    e.rst = 1'b1;
    bq.push_back(e);
    for (int i = 0; i < 30; i++) bq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, EXP_IDLE));
  endtask

  task automatic push_reset_head();
    ent_t e;
    e = mk(1'b0, 1'b0, 8'h00, 1'b0, EXP_IDLE);
    e.rst = 1'b1;
    e.chk = 1'b0;
    bq.push_back(e);
    e.chk = 1'b1;
    bq.push_back(e);
  endtask

  task automatic random_txns(input int T, input int count);
    for (int r = 0; r < count; r++) begin
      int n;
      n = $urandom_range(1, 4);
      tx_bytes.delete();
      tx_stalls.delete();
      for (int i = 0; i < n; i++) begin
        tx_bytes.push_back(8'($urandom_range(0, 255)));
        tx_stalls.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
      end
      build_txn(T, $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic drive(input int u, input ent_t e);
    if (u == 0) begin
      rst0 = e.rst; start0 = e.start; tvalid0 = e.tvalid; tlast0 = e.tlast; tdata0 = e.tdata;
    end else begin
      rst1 = e.rst; start1 = e.start; tvalid1 = e.tvalid; tlast1 = e.tlast; tdata1 = e.tdata;
    end
  endtask

  task automatic play(input int u);
    int       n, start_cyc, exp_lat;
    ent_t     e;
    bit [4:0] obs;
    n = (u == 0) ? q0.size() : q1.size();
    exp_lat = -1;
    start_cyc = 0;
    for (int i = 0; i < n; i++) begin
      e = (u == 0) ? q0[i] : q1[i];
      @(negedge clk);
      obs = (u == 0) ? {a0, b0, tready0, done0, busy0} : {a1, b1, tready1, done1, busy1};
      if (e.chk) check_val($sformatf("u%0d_cyc%0d_lines", u, i), 32'(obs), 32'(e.exp));
      if (obs[1] && exp_lat >= 0) begin
        check_val($sformatf("u%0d_cyc%0d_done_latency", u, i), i - start_cyc, exp_lat);
        exp_lat = -1;
      end
      if (e.rst) exp_lat = -1;
      if (e.txn) begin
        start_cyc = i;
        exp_lat = e.lat;
      end
      drive(u, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; start0 = 1'b0; tvalid0 = 1'b0; tlast0 = 1'b0; tdata0 = 8'h00;
    rst1 = 1'b1; start1 = 1'b0; tvalid1 = 1'b0; tlast1 = 1'b0; tdata1 = 8'h00;

    // unit 0: TICKS_PER_PHASE = 1
    bq.delete();
    push_reset_head();
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'hA5); tx_stalls.push_back(0);
    build_txn(1, 1, 1'b0);
    build_reset_mid(1, $urandom_range(1, 23));
    build_reset_mid(1, 24);
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'($urandom_range(0, 255))); tx_stalls.push_back(10);
    build_txn(1, 2, 1'b0);
    random_txns(1, 15);
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'h12); tx_stalls.push_back(0);
    tx_bytes.push_back(8'h34); tx_stalls.push_back(0);
    build_txn(1, 1, 1'b0);
    for (int i = 0; i < 5; i++) bq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, EXP_IDLE));
    q0 = bq;

    // unit 1: TICKS_PER_PHASE = 2
    bq.delete();
    push_reset_head();
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'hFF); tx_stalls.push_back(0);
    tx_bytes.push_back(8'h00); tx_stalls.push_back(0);
    build_txn(2, 1, 1'b0);
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'h96); tx_stalls.push_back(10);
    build_txn(2, 0, 1'b1);
    build_reset_mid(2, $urandom_range(1, 47));
    random_txns(2, 12);
    tx_bytes.delete(); tx_stalls.delete();
    tx_bytes.push_back(8'h12); tx_stalls.push_back(0);
    tx_bytes.push_back(8'h34); tx_stalls.push_back(0);
    build_txn(2, 0, 1'b0);
    for (int i = 0; i < 5; i++) bq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, EXP_IDLE));
    q1 = bq;

    fork
      play(0);
      play(1);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
